// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage:
// opcodes, result-mux selects, decoded-control record and FIFO states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SEL_ADD   = 2'b00,
        SEL_XOR   = 2'b01,
        SEL_SLT   = 2'b10,
        SEL_LOGIC = 2'b11
    } sel_e;

    typedef struct packed {
        sel_e sel;
        logic invb;
        logic invout;
        logic orsel;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_st_e;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to bit-slice control decoder.
// Pure combinational; record layout is {sel, invb, invout, orsel}.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] op_i,
    output logic       address0_o,
    output logic       address1_o,
    output logic       invb_o,
    output logic       invout_o,
    output logic       orsel_o
);

    logic [CTRL_W-1:0] rec;

    always_comb begin
        rec = '0;
        unique case (op_e'(op_i))
            OP_ADD:  rec = {SEL_ADD,   3'b000};
            OP_SUB:  rec = {SEL_ADD,   3'b100};
            OP_XOR:  rec = {SEL_XOR,   3'b000};
            OP_SLT:  rec = {SEL_SLT,   3'b100};
            OP_AND:  rec = {SEL_LOGIC, 3'b000};
            OP_NAND: rec = {SEL_LOGIC, 3'b010};
            OP_NOR:  rec = {SEL_LOGIC, 3'b011};
            OP_OR:   rec = {SEL_LOGIC, 3'b001};
            default: rec = '0;
        endcase
    end

    assign {address1_o, address0_o, invb_o, invout_o, orsel_o} = rec;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode on accept, 2-entry skid FIFO of decoded
// commands toward the bit-slice/mux stage, plus an issue counter.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_address0,
    output logic             out_address1,
    output logic             out_invb,
    output logic             out_invout,
    output logic             out_orsel,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [15:0]      issue_count
);

    import alu_pkg::*;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    fifo_st_e state_q, state_d;
    logic     init_q;
    logic     wr_ptr_q, rd_ptr_q;
    entry_t   mem_q [DEPTH];
    entry_t   head;
    logic [15:0] cnt_q;
    logic     push, pop;
    logic     d_a0, d_a1, d_invb, d_invout, d_orsel;
    ctrl_t    dec;

    alu_op_decode u_dec (
        .op_i       (in_op),
        .address0_o (d_a0),
        .address1_o (d_a1),
        .invb_o     (d_invb),
        .invout_o   (d_invout),
        .orsel_o    (d_orsel)
    );

    assign dec = '{sel: sel_e'({d_a1, d_a0}), invb: d_invb,
                   invout: d_invout, orsel: d_orsel};

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_d = ST_FULL;
                else if (pop && !push) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // in_ready stays low until the first edge after reset release
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_EMPTY: in_ready = init_q;
            ST_ONE: begin
                in_ready  = init_q;
                out_valid = 1'b1;
            end
            ST_FULL:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q   <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            init_q <= 1'b1;
            if (push) begin
                mem_q[wr_ptr_q] <= '{ctrl: dec, a: in_a, b: in_b};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                cnt_q    <= cnt_q + 16'd1;
            end
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign out_address0 = head.ctrl.sel[0];
    assign out_address1 = head.ctrl.sel[1];
    assign out_invb     = head.ctrl.invb;
    assign out_invout   = head.ctrl.invout;
    assign out_orsel    = head.ctrl.orsel;
    assign out_a        = head.a;
    assign out_b        = head.b;
    assign issue_count  = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter DEPTH, fixed at 2; number of entries in the skid buffer.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream command valid.
REQ-006 in_ready  output  1  stage can accept a command.
REQ-007 in_op  input  3  opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-008 in_a, in_b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  decoded command valid toward the bit-slice/mux stage.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_address0, out_address1  output  1 each  4:1 result-mux select; {address1,address0}: 00 adder, 01 xor, 10 slt, 11 logic.
REQ-012 out_invb  output  1  invert B and carry-in = 1 (subtract).
REQ-013 out_invout  output  1  invert logic-unit output.
REQ-014 out_orsel  output  1  logic unit uses OR, not AND.
REQ-015 out_a, out_b  output  WIDTH each  registered operands.
REQ-016 issue_count  output  16  commands issued downstream, modulo 2^16.

Function
REQ-017 Transfers occur only on cycles where valid and ready are both high at the clock edge.
REQ-018 Decode: ADD 00/invb0/inv0/or0; SUB 00/1/0/0; XOR 01/0/0/0; SLT 10/1/0/0; AND 11/0/0/0; NAND 11/0/1/0; NOR 11/0/1/1; OR 11/0/0/1.
REQ-019 Decode is performed at input acceptance; the buffer stores decoded fields and operands, not the opcode.
REQ-020 Buffer is a 2-entry FIFO with states EMPTY, ONE, FULL.
REQ-021 Transitions: EMPTY -> ONE on accept; ONE -> FULL on accept without issue; ONE -> EMPTY on issue without accept; ONE stays ONE on simultaneous accept and issue; FULL -> ONE on issue.
REQ-022 in_ready is high in EMPTY and ONE and low in FULL; it depends only on state and never combinationally on out_ready.
REQ-023 out_valid is high in ONE and FULL; outputs present the oldest entry.
REQ-024 Latency: a command accepted at edge N is visible on the outputs after edge N, with out_valid high, when the buffer was EMPTY.
REQ-025 While out_valid is high and out_ready is low, all out_* fields hold stable.
REQ-026 In FULL state, in_valid is ignored; no entry is overwritten.
REQ-027 Order is strictly FIFO; commands are never dropped or duplicated.
REQ-028 issue_count increments by 1 on each out_valid&&out_ready edge and wraps from 16'hFFFF to 0.
REQ-029 Buffer pointers are 1 bit and wrap naturally.

Reset
REQ-030 rst_n low forces state EMPTY, in_ready 0 during reset, out_valid 0, issue_count 0, and all out_* data/select fields 0, asynchronously.
REQ-031 in_ready rises on the first clock edge after rst_n deasserts.
REQ-032 Reset mid-operation discards all buffered entries; no issue occurs on that edge.

Structure
REQ-033 Opcode encodings, the 2-bit select encodings and the decoded-control record width are defined in shared package alu_pkg.
REQ-034 The decoder is a separate combinational sub-module alu_op_decode (opcode in; address0, address1, invb, invout, orsel out); the FIFO and counter stay in alu_issue_stage.

Verification
REQ-035 Reset is held, then released, with SUB, a=5, b=3, and out_ready=1 -> one cycle later out_valid=1, address=00, invb=1, out_a=5, out_b=3; issue_count=1 after the next edge.
REQ-036 All 8 opcodes are sent back-to-back with out_ready=1 -> outputs match the REQ-018 table in order; issue_count=8; in_ready stays 1.
REQ-037 out_ready=0 while NAND and then OR are pushed -> state FULL, in_ready=0, and a third command is ignored; out_ready=1 -> NAND (11/inv1/or0) issues, then OR (11/0/1).
REQ-038 In ONE state, simultaneous accept and issue for 100 cycles -> state stays ONE, and order and count (100) are correct.
REQ-039 rst_n is asserted mid-stream while FULL -> out_valid and issue_count drop to 0 immediately, and no stale entry appears after release.
REQ-040 issue_count is preloaded by 65535 issues, then one more issue -> issue_count=0.
